// File: rtl/raabb_fp_pkg.sv
// Shared definitions for FloPoCo 11_11 floats in the Ray-AABB datapath.
// The layout is exn[24:23], sign[22], exp[21:11], mant[10:0].
package raabb_fp_pkg;
  localparam int FP_W = 25;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam logic [FP_W-1:0] FP_NAN = 25'h1800000;

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;
endpackage

// File: rtl/fp_extremum_seq.sv
// Sequential min/max reducer over groups of FloPoCo floats, using an external pipelined A<B comparator.
// NAN_PROPAGATE_EN: defined -> NaN in a group forces a NaN result; undefined -> NaN operands are skipped.
module fp_extremum_seq
  import raabb_fp_pkg::*;
#(
  parameter int FP_W     = raabb_fp_pkg::FP_W,
  parameter int CMP_LAT  = 3,
  parameter int MODE_MAX = 1,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [FP_W-1:0]  cmp_a,
  output logic [FP_W-1:0]  cmp_b,
  input  logic             cmp_less,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
);
  localparam int WAIT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FP_W-1:0]  NAN_W   = FP_W'(FP_NAN);

  state_t            state, state_nx;
  logic              alive;
  logic [FP_W-1:0]   acc;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lastq;
  logic              accept, in_nan, sample, take, direct;
  logic [FP_W-1:0]   result;
`ifdef NAN_PROPAGATE_EN
  logic              nan_q;
`else
  logic              empty_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign in_nan = (in_data[FP_W-1 -: 2] == EXN_NAN);
  assign accept = in_valid && in_ready;
  assign sample = (state == CMP) && (wait_cnt == WAIT_W'(CMP_LAT - 1));
  assign take   = (MODE_MAX != 0) ? !cmp_less : cmp_less;

  // direct: the ACC operand bypasses the comparator (skipped NaN, or first real value)
`ifdef NAN_PROPAGATE_EN
  assign direct = 1'b0;
  assign result = nan_q ? NAN_W : acc;
`else
  assign direct = in_nan || empty_q;
  assign result = acc;
`endif

  assign in_ready  = alive && ((state == IDLE) || (state == ACC));
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? result : '0;
  assign out_count = out_valid ? cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = in_last ? DONE : ACC;
      ACC:  if (accept) state_nx = direct ? (in_last ? DONE : ACC) : CMP;
      CMP:  if (sample) state_nx = lastq ? DONE : ACC;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      lastq    <= 1'b0;
      cmp_a    <= '0;
      cmp_b    <= '0;
`ifdef NAN_PROPAGATE_EN
      nan_q    <= 1'b0;
`else
      empty_q  <= 1'b0;
`endif
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
`ifdef NAN_PROPAGATE_EN
          nan_q <= 1'b0;
`endif
          if (accept) begin
            cnt <= CNT_W'(1);
`ifdef NAN_PROPAGATE_EN
            acc   <= in_data;
            nan_q <= in_nan;
`else
            acc     <= in_nan ? NAN_W : in_data;
            empty_q <= in_nan;
`endif
          end
        end
        ACC: begin
          if (accept) begin
            cnt   <= sat_inc(cnt);
            lastq <= in_last;
`ifdef NAN_PROPAGATE_EN
            nan_q <= nan_q | in_nan;
`else
            if (!in_nan && empty_q) begin
              acc     <= in_data;
              empty_q <= 1'b0;
            end
`endif
            if (!direct) begin
              cmp_a    <= in_data;
              cmp_b    <= acc;
              wait_cnt <= '0;
            end
          end
        end
        CMP: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (sample && take) acc <= cmp_a;
        end
        default: ;
      endcase
    end
  end
endmodule
